// File: rtl/centroid_calc_if.sv
// Pixel-stream and centroid-result bundle between the binarised camera front end,
// the centroid calculator and the servo trackers.
interface centroid_calc_if #(
    parameter int CNT_W = 20
);
    logic             vs;
    logic             de;
    logic             pix_bin;
    logic [11:0]      cen_x;
    logic [11:0]      cen_y;
    logic             cen_valid;
    logic             found;
    logic [CNT_W-1:0] pix_cnt;
    logic             busy;

    modport master (
        output vs, de, pix_bin,
        input  cen_x, cen_y, cen_valid, found, pix_cnt, busy
    );

    modport slave (
        input  vs, de, pix_bin,
        output cen_x, cen_y, cen_valid, found, pix_cnt, busy
    );
endinterface

// File: rtl/centroid_calc.sv
// Per-frame target centroid: accumulates coordinate sums of mask pixels, then
// divides by the pixel count with two bit-serial restoring dividers at frame end.
module centroid_calc #(
    parameter int H_ACT   = 640,
    parameter int V_ACT   = 480,
    parameter int SUM_W   = 32,
    parameter int CNT_W   = 20,
    parameter int MIN_PIX = 16
) (
    input logic            clk_pix,
    input logic            rst,
    centroid_calc_if.slave bus
);
    localparam int               K_W       = $clog2(SUM_W);
    localparam logic [11:0]      CRD_MAX   = 12'hFFF;
    localparam logic [11:0]      CEN_X_RST = 12'(H_ACT / 2);
    localparam logic [11:0]      CEN_Y_RST = 12'(V_ACT / 2);
    localparam logic [11:0]      H_LIM     = 12'(H_ACT);
    localparam logic [11:0]      V_LIM     = 12'(V_ACT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_CNT   = CNT_W'(MIN_PIX);
    localparam logic [K_W-1:0]   K_LAST    = K_W'(SUM_W - 1);

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_DIV = 2'd1,
        ST_OUT = 2'd2
    } state_t;

    // One restoring-division step: returns {quotient_bit, new_remainder}.
    function automatic logic [SUM_W:0] div_step(
        input logic [SUM_W-1:0] rem,
        input logic             nbit,
        input logic [SUM_W:0]   den
    );
        logic [SUM_W:0] sh;
        logic [SUM_W:0] res;
        sh = {rem, nbit};
        if (sh >= den) begin
            res = {1'b1, SUM_W'(sh - den)};
        end else begin
            res = {1'b0, sh[SUM_W-1:0]};
        end
        return res;
    endfunction

    logic             de_d_r;
    logic             vs_d_r;
    logic [11:0]      x_cnt_r;
    logic [11:0]      y_cnt_r;
    logic [SUM_W-1:0] sum_x_r;
    logic [SUM_W-1:0] sum_y_r;
    logic [CNT_W-1:0] cnt_r;

    state_t           state_r;
    state_t           state_s;
    logic             snap_s;

    logic [K_W-1:0]   k_r;
    logic [SUM_W-1:0] num_x_r;
    logic [SUM_W-1:0] num_y_r;
    logic [SUM_W-1:0] rem_x_r;
    logic [SUM_W-1:0] rem_y_r;
    logic [11:0]      quo_x_r;
    logic [11:0]      quo_y_r;
    logic [CNT_W-1:0] den_r;
    logic [SUM_W:0]   den_ext_s;
    logic [SUM_W:0]   step_x_s;
    logic [SUM_W:0]   step_y_s;

    logic [11:0]      cen_x_r;
    logic [11:0]      cen_y_r;
    logic             cen_valid_r;
    logic             found_r;
    logic [CNT_W-1:0] pix_cnt_r;
    logic             busy_r;

    logic             line_end_s;
    logic             frame_end_s;
    logic             acc_en_s;

    assign line_end_s  = de_d_r & ~bus.de;
    assign frame_end_s = bus.vs & ~vs_d_r;
    assign acc_en_s    = bus.de & bus.pix_bin & (x_cnt_r < H_LIM) & (y_cnt_r < V_LIM);
    assign den_ext_s   = {{(SUM_W + 1 - CNT_W){1'b0}}, den_r};
    assign step_x_s    = div_step(rem_x_r, num_x_r[SUM_W-1], den_ext_s);
    assign step_y_s    = div_step(rem_y_r, num_y_r[SUM_W-1], den_ext_s);

    // Timing-edge detection registers.
    always_ff @(posedge clk_pix or negedge rst) begin
        if (!rst) begin
            de_d_r <= 1'b0;
            vs_d_r <= 1'b0;
        end else begin
            de_d_r <= bus.de;
            vs_d_r <= bus.vs;
        end
    end

    // Saturating pixel/line coordinate counters.
    always_ff @(posedge clk_pix or negedge rst) begin
        if (!rst) begin
            x_cnt_r <= 12'd0;
            y_cnt_r <= 12'd0;
        end else begin
            if (bus.de) begin
                if (x_cnt_r != CRD_MAX) begin
                    x_cnt_r <= x_cnt_r + 12'd1;
                end
            end else begin
                x_cnt_r <= 12'd0;
            end
            if (frame_end_s) begin
                y_cnt_r <= 12'd0;
            end else if (line_end_s && (y_cnt_r != CRD_MAX)) begin
                y_cnt_r <= y_cnt_r + 12'd1;
            end
        end
    end

    // Target-pixel accumulators; frame end wipes them even when the result is dropped.
    always_ff @(posedge clk_pix or negedge rst) begin
        if (!rst) begin
            sum_x_r <= {SUM_W{1'b0}};
            sum_y_r <= {SUM_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else if (frame_end_s) begin
            sum_x_r <= {SUM_W{1'b0}};
            sum_y_r <= {SUM_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else if (acc_en_s) begin
            sum_x_r <= sum_x_r + SUM_W'(x_cnt_r);
            sum_y_r <= sum_y_r + SUM_W'(y_cnt_r);
            if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_pix or negedge rst) begin
        if (!rst) begin
            state_r <= ST_ACC;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state and snapshot strobe.
    always_comb begin
        state_s = state_r;
        snap_s  = 1'b0;
        case (state_r)
            ST_ACC: begin
                if (frame_end_s) begin
                    state_s = ST_DIV;
                    snap_s  = 1'b1;
                end else begin
                    state_s = ST_ACC;
                end
            end
            ST_DIV: begin
                if (k_r == {K_W{1'b0}}) begin
                    state_s = ST_OUT;
                end else begin
                    state_s = ST_DIV;
                end
            end
            ST_OUT:  state_s = ST_ACC;
            default: state_s = ST_ACC;
        endcase
    end

    // Dual restoring divider, one quotient bit per cycle, MSB first.
    always_ff @(posedge clk_pix or negedge rst) begin
        if (!rst) begin
            k_r     <= {K_W{1'b0}};
            num_x_r <= {SUM_W{1'b0}};
            num_y_r <= {SUM_W{1'b0}};
            rem_x_r <= {SUM_W{1'b0}};
            rem_y_r <= {SUM_W{1'b0}};
            quo_x_r <= 12'd0;
            quo_y_r <= 12'd0;
            den_r   <= {CNT_W{1'b0}};
        end else if (snap_s) begin
            k_r     <= K_LAST;
            num_x_r <= sum_x_r;
            num_y_r <= sum_y_r;
            rem_x_r <= {SUM_W{1'b0}};
            rem_y_r <= {SUM_W{1'b0}};
            quo_x_r <= 12'd0;
            quo_y_r <= 12'd0;
            den_r   <= cnt_r;
        end else if (state_r == ST_DIV) begin
            // The centroid lies inside the active area, so the quotient fits 12 bits.
            num_x_r <= {num_x_r[SUM_W-2:0], 1'b0};
            num_y_r <= {num_y_r[SUM_W-2:0], 1'b0};
            rem_x_r <= step_x_s[SUM_W-1:0];
            rem_y_r <= step_y_s[SUM_W-1:0];
            quo_x_r <= {quo_x_r[10:0], step_x_s[SUM_W]};
            quo_y_r <= {quo_y_r[10:0], step_y_s[SUM_W]};
            if (k_r != {K_W{1'b0}}) begin
                k_r <= k_r - K_W'(1);
            end
        end
    end

    // Result registers; a too-small target reports the centre to park the servos.
    always_ff @(posedge clk_pix or negedge rst) begin
        if (!rst) begin
            cen_x_r     <= CEN_X_RST;
            cen_y_r     <= CEN_Y_RST;
            cen_valid_r <= 1'b0;
            found_r     <= 1'b0;
            pix_cnt_r   <= {CNT_W{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            cen_valid_r <= 1'b0;
            if (state_r == ST_OUT) begin
                cen_valid_r <= 1'b1;
                busy_r      <= 1'b0;
                pix_cnt_r   <= den_r;
                if (den_r >= MIN_CNT) begin
                    found_r <= 1'b1;
                    cen_x_r <= quo_x_r;
                    cen_y_r <= quo_y_r;
                end else begin
                    found_r <= 1'b0;
                    cen_x_r <= CEN_X_RST;
                    cen_y_r <= CEN_Y_RST;
                end
            end else if (snap_s) begin
                busy_r <= 1'b1;
            end
        end
    end

    assign bus.cen_x     = cen_x_r;
    assign bus.cen_y     = cen_y_r;
    assign bus.cen_valid = cen_valid_r;
    assign bus.found     = found_r;
    assign bus.pix_cnt   = pix_cnt_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_centroid_calc.sv
// Directed bench: one default-size instance (A, MIN_PIX=16) and one reduced 128x64
// instance (B, MIN_PIX=1) share the same pixel stream.
module tb_centroid_calc;
    logic clk_pix = 1'b0;
    logic rst     = 1'b0;
    logic vs_s    = 1'b0;
    logic de_s    = 1'b0;
    logic pix_s   = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int va       = 0;
    int vb       = 0;
    int va_cyc   = 0;
    int vb_cyc   = 0;
    int rise_cyc = 0;
    int va0;
    int vb0;

    centroid_calc_if #(.CNT_W(20)) ifa ();
    centroid_calc_if #(.CNT_W(20)) ifb ();

    assign ifa.vs      = vs_s;
    assign ifa.de      = de_s;
    assign ifa.pix_bin = pix_s;
    assign ifb.vs      = vs_s;
    assign ifb.de      = de_s;
    assign ifb.pix_bin = pix_s;

    centroid_calc dut_a (
        .clk_pix (clk_pix),
        .rst     (rst),
        .bus     (ifa)
    );

    centroid_calc #(.H_ACT(128), .V_ACT(64), .MIN_PIX(1)) dut_b (
        .clk_pix (clk_pix),
        .rst     (rst),
        .bus     (ifb)
    );

    always #5 clk_pix = ~clk_pix;

    always @(posedge clk_pix) cyc <= cyc + 1;

    always @(negedge clk_pix) begin
        if (ifa.cen_valid === 1'b1) begin
            va     <= va + 1;
            va_cyc <= cyc;
        end
        if (ifb.cen_valid === 1'b1) begin
            vb     <= vb + 1;
            vb_cyc <= cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_pix);
            #1;
        end
    endtask

    task automatic send_line(input int len, input int xlo, input int xhi);
        for (int i = 0; i < len; i++) begin
            de_s  = 1'b1;
            pix_s = (i >= xlo) && (i <= xhi);
            step(1);
        end
        de_s  = 1'b0;
        pix_s = 1'b0;
        step(2);
    endtask

    task automatic blank_lines(input int n);
        for (int i = 0; i < n; i++) send_line(1, 1, 0);
    endtask

    task automatic frame_end();
        vs_s     = 1'b1;
        rise_cyc = cyc;
        step(1);
        vs_s = 1'b0;
        step(2);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(3);
        checks++; if (ifa.cen_x !== 12'd320) begin failures++; $display("FAIL reset_cen_x_a got=%0d exp=320", ifa.cen_x); end
        checks++; if (ifa.cen_y !== 12'd240) begin failures++; $display("FAIL reset_cen_y_a got=%0d exp=240", ifa.cen_y); end
        checks++; if ({ifa.cen_valid, ifa.found, ifa.busy} !== 3'b000) begin failures++; $display("FAIL reset_flags_a got=%b exp=000", {ifa.cen_valid, ifa.found, ifa.busy}); end
        checks++; if (ifa.pix_cnt !== 20'd0) begin failures++; $display("FAIL reset_pix_cnt_a got=%0d exp=0", ifa.pix_cnt); end
        checks++; if ({ifb.cen_x, ifb.cen_y} !== {12'd64, 12'd32}) begin failures++; $display("FAIL reset_cen_b got=%0d,%0d exp=64,32", ifb.cen_x, ifb.cen_y); end
        rst = 1'b1;
        step(2);
    endtask

    task automatic test_single_pixel();
        blank_lines(50);
        send_line(101, 100, 100);
        va0 = va; vb0 = vb;
        frame_end();
        checks++; if (ifb.busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", ifb.busy); end
        step(40);
        checks++; if (vb - vb0 !== 1) begin failures++; $display("FAIL single_pulses_b got=%0d exp=1", vb - vb0); end
        checks++; if (vb_cyc - rise_cyc !== 34) begin failures++; $display("FAIL single_latency got=%0d exp=34", vb_cyc - rise_cyc); end
        checks++; if ({ifb.cen_x, ifb.cen_y} !== {12'd100, 12'd50}) begin failures++; $display("FAIL single_cen_b got=%0d,%0d exp=100,50", ifb.cen_x, ifb.cen_y); end
        checks++; if ({ifb.found, ifb.pix_cnt} !== {1'b1, 20'd1}) begin failures++; $display("FAIL single_found_cnt_b got=%b,%0d exp=1,1", ifb.found, ifb.pix_cnt); end
        checks++; if (ifb.busy !== 1'b0) begin failures++; $display("FAIL single_busy_done got=%b exp=0", ifb.busy); end
        checks++; if ({ifa.found, ifa.pix_cnt, ifa.cen_x, ifa.cen_y} !== {1'b0, 20'd1, 12'd320, 12'd240}) begin failures++; $display("FAIL single_below_min_a got=%b,%0d,%0d,%0d exp=0,1,320,240", ifa.found, ifa.pix_cnt, ifa.cen_x, ifa.cen_y); end
        checks++; if (va - va0 !== 1) begin failures++; $display("FAIL single_pulses_a got=%0d exp=1", va - va0); end
    endtask

    task automatic test_block();
        blank_lines(200);
        for (int i = 0; i < 10; i++) send_line(310, 300, 309);
        va0 = va;
        frame_end();
        step(40);
        checks++; if (va - va0 !== 1) begin failures++; $display("FAIL block_pulses got=%0d exp=1", va - va0); end
        checks++; if ({ifa.cen_x, ifa.cen_y} !== {12'd304, 12'd204}) begin failures++; $display("FAIL block_cen got=%0d,%0d exp=304,204", ifa.cen_x, ifa.cen_y); end
        checks++; if ({ifa.found, ifa.pix_cnt} !== {1'b1, 20'd100}) begin failures++; $display("FAIL block_found_cnt got=%b,%0d exp=1,100", ifa.found, ifa.pix_cnt); end
        checks++; if ({ifb.found, ifb.pix_cnt, ifb.cen_x, ifb.cen_y} !== {1'b0, 20'd0, 12'd64, 12'd32}) begin failures++; $display("FAIL block_outside_b got=%b,%0d,%0d,%0d exp=0,0,64,32", ifb.found, ifb.pix_cnt, ifb.cen_x, ifb.cen_y); end
    endtask

    task automatic test_low_count();
        va0 = va;
        frame_end();
        step(40);
        checks++; if (va - va0 !== 1) begin failures++; $display("FAIL empty_pulses got=%0d exp=1", va - va0); end
        checks++; if ({ifa.found, ifa.pix_cnt, ifa.cen_x, ifa.cen_y} !== {1'b0, 20'd0, 12'd320, 12'd240}) begin failures++; $display("FAIL empty_result got=%b,%0d,%0d,%0d exp=0,0,320,240", ifa.found, ifa.pix_cnt, ifa.cen_x, ifa.cen_y); end
        send_line(8, 5, 7);
        va0 = va;
        frame_end();
        step(40);
        checks++; if (va - va0 !== 1) begin failures++; $display("FAIL three_pulses got=%0d exp=1", va - va0); end
        checks++; if ({ifa.found, ifa.pix_cnt, ifa.cen_x, ifa.cen_y} !== {1'b0, 20'd3, 12'd320, 12'd240}) begin failures++; $display("FAIL three_result got=%b,%0d,%0d,%0d exp=0,3,320,240", ifa.found, ifa.pix_cnt, ifa.cen_x, ifa.cen_y); end
    endtask

    task automatic test_full_white();
        for (int i = 0; i < 66; i++) send_line(138, 0, 137);
        vb0 = vb;
        frame_end();
        step(40);
        checks++; if (vb - vb0 !== 1) begin failures++; $display("FAIL white_pulses_b got=%0d exp=1", vb - vb0); end
        checks++; if ({ifb.found, ifb.pix_cnt} !== {1'b1, 20'd8192}) begin failures++; $display("FAIL white_cnt_b got=%b,%0d exp=1,8192", ifb.found, ifb.pix_cnt); end
        checks++; if ({ifb.cen_x, ifb.cen_y} !== {12'd63, 12'd31}) begin failures++; $display("FAIL white_cen_b got=%0d,%0d exp=63,31", ifb.cen_x, ifb.cen_y); end
        checks++; if ({ifa.pix_cnt, ifa.cen_x, ifa.cen_y} !== {20'd9108, 12'd68, 12'd32}) begin failures++; $display("FAIL white_a got=%0d,%0d,%0d exp=9108,68,32", ifa.pix_cnt, ifa.cen_x, ifa.cen_y); end
    endtask

    task automatic frame_small();
        for (int i = 0; i < 4; i++) send_line(24, 20, 23);
    endtask

    task automatic test_back_to_back();
        blank_lines(2);
        for (int i = 0; i < 4; i++) send_line(15, 10, 14);
        va0 = va;
        vs_s     = 1'b1;
        rise_cyc = cyc;
        step(1);
        vs_s = 1'b0;
        step(1);
        send_line(5, 0, 4);
        step(1);
        vs_s = 1'b1;
        step(1);
        vs_s = 1'b0;
        step(40);
        checks++; if (va - va0 !== 1) begin failures++; $display("FAIL drop_pulses got=%0d exp=1", va - va0); end
        checks++; if (va_cyc - rise_cyc !== 34) begin failures++; $display("FAIL drop_latency got=%0d exp=34", va_cyc - rise_cyc); end
        checks++; if ({ifa.found, ifa.pix_cnt, ifa.cen_x, ifa.cen_y} !== {1'b1, 20'd20, 12'd12, 12'd3}) begin failures++; $display("FAIL drop_first_result got=%b,%0d,%0d,%0d exp=1,20,12,3", ifa.found, ifa.pix_cnt, ifa.cen_x, ifa.cen_y); end
        frame_small();
        va0 = va;
        frame_end();
        step(40);
        checks++; if (va - va0 !== 1) begin failures++; $display("FAIL drop_next_pulses got=%0d exp=1", va - va0); end
        checks++; if ({ifa.found, ifa.pix_cnt, ifa.cen_x, ifa.cen_y} !== {1'b1, 20'd16, 12'd21, 12'd1}) begin failures++; $display("FAIL drop_next_result got=%b,%0d,%0d,%0d exp=1,16,21,1", ifa.found, ifa.pix_cnt, ifa.cen_x, ifa.cen_y); end
    endtask

    task automatic test_reset_mid_div();
        frame_small();
        frame_end();
        step(7);
        checks++; if (ifa.busy !== 1'b1) begin failures++; $display("FAIL middiv_busy_before got=%b exp=1", ifa.busy); end
        va0 = va;
        rst = 1'b0;
        #1;
        checks++; if ({ifa.found, ifa.busy, ifa.pix_cnt, ifa.cen_x, ifa.cen_y} !== {2'b00, 20'd0, 12'd320, 12'd240}) begin failures++; $display("FAIL middiv_reset_out got=%b,%b,%0d,%0d,%0d exp=0,0,0,320,240", ifa.found, ifa.busy, ifa.pix_cnt, ifa.cen_x, ifa.cen_y); end
        step(2);
        rst = 1'b1;
        step(40);
        checks++; if (va - va0 !== 0) begin failures++; $display("FAIL middiv_no_pulse got=%0d exp=0", va - va0); end
        checks++; if (ifa.found !== 1'b0) begin failures++; $display("FAIL middiv_found_hold got=%b exp=0", ifa.found); end
        frame_small();
        va0 = va;
        frame_end();
        step(40);
        checks++; if (va - va0 !== 1) begin failures++; $display("FAIL middiv_next_pulses got=%0d exp=1", va - va0); end
        checks++; if ({ifa.found, ifa.pix_cnt, ifa.cen_x, ifa.cen_y} !== {1'b1, 20'd16, 12'd21, 12'd1}) begin failures++; $display("FAIL middiv_next_result got=%b,%0d,%0d,%0d exp=1,16,21,1", ifa.found, ifa.pix_cnt, ifa.cen_x, ifa.cen_y); end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_block();
        test_low_count();
        test_full_white();
        test_back_to_back();
        test_reset_mid_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
